// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and constants for the sequential multiplier
// Purpose: FSM state encoding, default operand width and counter sizing helper.
// Ports: none (package).
// Configuration macro: SEQ_MULT_SIGNED_EN (consumed by seq_shift_add_mult).
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 5;

  // Step counter must hold WIDTH-1 for every legal WIDTH (2..16).
  function automatic int count_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_mult_addsub.sv
// rtl/seq_mult_addsub.sv - WIDTH+1-bit ripple adder/subtractor
// Purpose: computes x + y, or x - y when sub is high (invert y, carry-in 1).
// Ports:
//   x   in  WIDTH+1  left operand
//   y   in  WIDTH+1  right operand
//   sub in  1        0: add, 1: subtract
//   sum out WIDTH+1  result, carry-out discarded (caller sizes operands so none is lost)
module seq_mult_addsub #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH:0] x,
  input  logic [WIDTH:0] y,
  input  logic           sub,
  output logic [WIDTH:0] sum
);

  logic carry;
  logic yb;

  always_comb begin
    sum   = '0;
    carry = sub;
    yb    = 1'b0;
    for (int i = 0; i <= WIDTH; i++) begin
      yb     = y[i] ^ sub;
      sum[i] = x[i] ^ yb ^ carry;
      carry  = (x[i] & yb) | (carry & (x[i] ^ yb));
    end
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - sequential shift-and-add multiplier, one partial product per clock
// Purpose: multiplies a by b over WIDTH RUN cycles with a start/busy/done handshake.
// Ports:
//   CLOCK_50 in  1        system clock, rising edge
//   RST      in  1        asynchronous active-high reset
//   start    in  1        latch a/b and begin; honoured only in IDLE
//   a        in  WIDTH    multiplicand
//   b        in  WIDTH    multiplier
//   busy     out 1        high in RUN
//   done     out 1        one-cycle pulse when product updates
//   product  out 2*WIDTH  last result, held until the next done
// Configuration macro: SEQ_MULT_SIGNED_EN selects two's complement operands/result.
module seq_shift_add_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               CLOCK_50,
  input  logic               RST,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int            CW   = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, next_state;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;

  logic             last_step;
  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   add_y;
  logic             add_sub;
  logic [WIDTH:0]   sum;

  assign last_step = (count == LAST);

`ifdef SEQ_MULT_SIGNED_EN
  // Sign-extend into the extra bit; the last multiplier bit carries weight
  // -2^(WIDTH-1), so it subtracts the multiplicand instead of adding it.
  assign add_x   = {acc[WIDTH-1], acc};
  assign add_y   = mplier[0] ? {mcand[WIDTH-1], mcand} : '0;
  assign add_sub = last_step & mplier[0];
`else
  assign add_x   = {1'b0, acc};
  assign add_y   = mplier[0] ? {1'b0, mcand} : '0;
  assign add_sub = 1'b0;
`endif

  seq_mult_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x   (add_x),
    .y   (add_y),
    .sub (add_sub),
    .sum (sum)
  );

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          // Shift {sum, mplier} right by one. sum's top bit is the carry
          // (unsigned) or the sign (signed), so this one form serves both.
          acc    <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          count  <= count + CW'(1);
        end
        DONE: begin
          product <= {acc, mplier};
          done    <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb/tb_seq_shift_add_mult.sv - self-checking bench for seq_shift_add_mult
module tb_seq_shift_add_mult;

  localparam int W = 5;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  logic [2*W-1:0] sb[$];
  int pass_cnt;
  int total_cnt;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
`ifdef SEQ_MULT_SIGNED_EN
    int sx;
    int sy;
    sx = $signed(x);
    sy = $signed(y);
    p  = sx * sy;
`else
    p = int'(x) * int'(y);
`endif
    return p[2*W-1:0];
  endfunction

  function automatic logic [2*W-1:0] pop_exp();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  // Drive a start request at a falling edge and record the expected result.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    sb.push_back(model(x, y));
  endtask

  // Observe falling edges until done; lat counts edges after the start was driven.
  task automatic wait_done(input bit drop_start, output int lat, output int busy_cycles,
                           output bit early);
    logic [2*W-1:0] prev;
    prev        = product;
    lat         = -1;
    busy_cycles = 0;
    early       = 1'b0;
    for (int k = 1; k <= 4 * W + 8; k++) begin
      @(negedge clk);
      if (drop_start) start = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        lat = k;
        break;
      end
      if (product !== prev) early = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy, done, product} !== '0) $display("FAIL reset_state: busy=%b done=%b product=%0d, want 0/0/0", busy, done, product);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b, want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_full_scale;
    int lat, bc;
    bit early;
    logic [2*W-1:0] exp;
    start_op(5'd31, 5'd31);
    wait_done(1'b1, lat, bc, early);
    exp = pop_exp();
    total_cnt++;
    if (lat !== W + 2) $display("FAIL full_latency: got %0d edges, want %0d", lat, W + 2);
    else pass_cnt++;
    total_cnt++;
    if (bc !== W) $display("FAIL full_busy: busy for %0d cycles, want %0d", bc, W);
    else pass_cnt++;
    total_cnt++;
    if (product !== exp) $display("FAIL full_product: got %0d, want %0d", product, exp);
    else pass_cnt++;
`ifndef SEQ_MULT_SIGNED_EN
    total_cnt++;
    if (product !== 10'd961) $display("FAIL full_literal: got %0d, want 961", product);
    else pass_cnt++;
`endif
    total_cnt++;
    if (early !== 1'b0) $display("FAIL full_no_partial: product moved before done");
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL full_done_pulse: done=%b one cycle later, want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_patterns;
    int lat, bc;
    bit early;
    logic [2*W-1:0] exp;
    logic [W-1:0] xs[3];
    logic [W-1:0] ys[3];
    xs = '{5'd13, 5'd0, 5'd1};
    ys = '{5'd11, 5'd17, 5'd30};
    for (int i = 0; i < 3; i++) begin
      start_op(xs[i], ys[i]);
      wait_done(1'b1, lat, bc, early);
      exp = pop_exp();
      total_cnt++;
      if (product !== exp) $display("FAIL pattern_product[%0d]: got %0d, want %0d", i, product, exp);
      else pass_cnt++;
      total_cnt++;
      if (lat !== W + 2) $display("FAIL pattern_latency[%0d]: got %0d, want %0d", i, lat, W + 2);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_ignored;
    int lat, bc, extra;
    bit early;
    logic [2*W-1:0] exp;
    start_op(5'd3, 5'd5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = 5'd7;
    b     = 5'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, lat, bc, early);
    exp = pop_exp();
    total_cnt++;
    if (product !== exp) $display("FAIL ignore_product: got %0d, want %0d", product, exp);
    else pass_cnt++;
    total_cnt++;
    if (lat !== W + 2 - 3) $display("FAIL ignore_latency: got %0d, want %0d", lat, W - 1);
    else pass_cnt++;
    extra = 0;
    for (int k = 0; k < 2 * W + 4; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    total_cnt++;
    if (extra !== 0) $display("FAIL ignore_single_done: %0d extra done pulses, want 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_abort;
    int lat, bc, seen;
    bit early;
    logic [2*W-1:0] exp;
    start_op(5'd9, 5'd9);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, done, product} !== '0) $display("FAIL abort_async: busy=%b done=%b product=%0d, want 0/0/0", busy, done, product);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    seen = 0;
    for (int k = 0; k < 2 * W + 4; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    total_cnt++;
    if (seen !== 0 || product !== '0) $display("FAIL abort_no_done: done pulses=%0d product=%0d, want 0/0", seen, product);
    else pass_cnt++;
    start_op(5'd7, 5'd9);
    wait_done(1'b1, lat, bc, early);
    exp = pop_exp();
    total_cnt++;
    if (product !== exp) $display("FAIL abort_recover: got %0d, want %0d", product, exp);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    bit early;
    logic [2*W-1:0] exp;
    start_op(5'd3, 5'd5);
    wait_done(1'b0, lat, bc, early);
    for (int i = 0; i < 3; i++) begin
      exp = pop_exp();
      total_cnt++;
      if (product !== exp || lat !== W + 2) $display("FAIL b2b[%0d]: product=%0d lat=%0d, want %0d lat=%0d", i, product, lat, exp, W + 2);
      else pass_cnt++;
      if (i < 2) begin
        a = 5'd6 + 5'(i * 9);
        b = 5'd7 + 5'(i * 11);
        sb.push_back(model(a, b));
        wait_done(1'b0, lat, bc, early);
      end else begin
        start = 1'b0;
      end
    end
    repeat (W + 3) @(negedge clk);
    total_cnt++;
    if (sb.size() !== 0) $display("FAIL b2b_drain: %0d results outstanding, want 0", sb.size());
    else pass_cnt++;
  endtask

`ifdef SEQ_MULT_SIGNED_EN
  task automatic test_signed;
    int lat, bc;
    bit early;
    logic [2*W-1:0] exp;
    logic [W-1:0]   xs[3];
    logic [W-1:0]   ys[3];
    logic [2*W-1:0] lit[3];
    xs  = '{5'h10, 5'h1f, 5'h10};
    ys  = '{5'd15, 5'h1f, 5'h10};
    lit = '{10'h310, 10'd1, 10'd256};
    for (int i = 0; i < 3; i++) begin
      start_op(xs[i], ys[i]);
      wait_done(1'b1, lat, bc, early);
      exp = pop_exp();
      total_cnt++;
      if (product !== exp || product !== lit[i]) $display("FAIL signed[%0d]: got %h, want %h", i, product, lit[i]);
      else pass_cnt++;
    end
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_full_scale();
    test_patterns();
    test_start_ignored();
    test_abort();
    test_back_to_back();
`ifdef SEQ_MULT_SIGNED_EN
    test_signed();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
